// File: rtl/serial_link_pkg.sv
// Shared types and helpers for the parametrised serial character link.
package serial_link_pkg;

  // Transmitter frame phases; every phase except IDLE lasts whole bit periods.
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  // Widest character the link supports; the parity helper works on this width.
  localparam int MAX_DATA_W = 16;

  // Total bits on the line per character: start + data + optional parity + stops.
  function automatic int frame_bits(input int data_w, input int parity_en, input int stop_bits);
    return 1 + data_w + parity_en + stop_bits;
  endfunction

  // Parity of a character zero-extended to MAX_DATA_W (extension does not change it).
  function automatic logic parity_bit(input logic [MAX_DATA_W-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/serial_char_tx_sync_fifo.sv
// Synchronous FIFO with occupancy counter; read data is the current head (no bypass).
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  // A push into a full FIFO is only accepted when the head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign rd_data = mem[rd_ptr];

  // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Character storage.
  // NOTE: the array is deliberately left out of reset; emptiness is tracked by
  // the counter alone, and an unreset array maps onto plain RAM/register files.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/serial_char_tx.sv
// Parametrised serial character transmitter: FIFO-buffered, start/data/parity/stop framing.
module serial_char_tx
  import serial_link_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4,
  parameter int PARITY_EN    = 1,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1,
  localparam int FRAME_BITS  = frame_bits(DATA_W, PARITY_EN, STOP_BITS),
  localparam int BIC_W       = $clog2(FRAME_BITS + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] data_in,
  input  logic              transmit,
  output logic              tx_serial,
  output logic              busy,
  output logic [BIC_W-1:0]  bic,
  output logic              char_done,
  output logic              fifo_full,
  output logic              fifo_empty,
  output logic              overflow
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);

  tx_state_t         state;
  tx_state_t         state_next;
  logic [BAUD_W-1:0] baud_cnt;
  logic [BIC_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] shift_q;
  logic              parity_q;
  logic [DATA_W-1:0] fifo_head;
  logic              start_ok;
  logic              bit_end;
  logic              frame_end;
  logic              pop;

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (load),
    .pop     (pop),
    .wr_data (data_in),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // bit_cnt indexes the frame: 0 = start, 1..DATA_W = data, then parity, then stops.
  assign start_ok  = transmit && !fifo_empty;
  assign bit_end   = (state != IDLE) && (baud_cnt == BAUD_W'(CLKS_PER_BIT - 1));
  assign frame_end = (state == STOP) && bit_end && (bit_cnt == BIC_W'(FRAME_BITS - 1));
  assign pop       = start_ok && ((state == IDLE) || frame_end);

  // State register.
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state selection; transmit matters only in IDLE and at the end of STOP.
  always_comb begin
    // NOTE: default first so every path assigns state_next and no latch is inferred.
    state_next = state;
    unique case (state)
      IDLE:    if (start_ok) state_next = START;
      START:   if (bit_end) state_next = DATA;
      DATA:    if (bit_end && (bit_cnt == BIC_W'(DATA_W)))
                 state_next = (PARITY_EN != 0) ? PARITY : STOP;
      PARITY:  if (bit_end) state_next = STOP;
      STOP:    if (frame_end) state_next = start_ok ? START : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Baud timing, frame bit counter, and the character/parity captured at pop time.
  always_ff @(posedge clk) begin
    if (reset) begin
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
    end else if (pop) begin
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift_q  <= fifo_head;
      parity_q <= parity_bit(MAX_DATA_W'(fifo_head), 1'(PARITY_ODD));
    end else if (state == IDLE) begin
      baud_cnt <= '0;
      bit_cnt  <= '0;
    end else if (bit_end) begin
      baud_cnt <= '0;
      bit_cnt  <= frame_end ? '0 : bit_cnt + BIC_W'(1);
      if (state == DATA) shift_q <= shift_q >> 1;
    end else begin
      baud_cnt <= baud_cnt + BAUD_W'(1);
    end
  end

  // Sticky flag: a load arrived while full and nothing left the FIFO that cycle.
  always_ff @(posedge clk) begin
    if (reset)                           overflow <= 1'b0;
    else if (load && fifo_full && !pop)  overflow <= 1'b1;
  end

  // Line level and status derived from the current phase.
  always_comb begin
    tx_serial = 1'b1;
    unique case (state)
      START:   tx_serial = 1'b0;
      DATA:    tx_serial = shift_q[0];
      PARITY:  tx_serial = parity_q;
      default: tx_serial = 1'b1;
    endcase
    busy      = (state != IDLE);
    char_done = frame_end;
    // The bit being sent counts as done on the last cycle of its period.
    bic       = bit_cnt + BIC_W'(bit_end);
  end

endmodule

// File: tb/tb_serial_char_tx.sv
// Self-checking bench for serial_char_tx: directed sequence with random characters,
// every cycle of every frame compared against a frame built from the framing rules.
module tb_serial_char_tx;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       load1, transmit1, load2, transmit2;
  logic [7:0] data1, data2;
  logic       tx1, busy1, done1, full1, empty1, ovf1;
  logic       tx2, busy2, done2, full2, empty2, ovf2;
  logic [3:0] bic1, bic2;

  int n_checks = 0;
  int n_errors = 0;

  // Default configuration: even parity, one stop bit.
  serial_char_tx #(
    .DATA_W(8), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(4),
    .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)
  ) dut (
    .clk(clk), .reset(reset), .load(load1), .data_in(data1), .transmit(transmit1),
    .tx_serial(tx1), .busy(busy1), .bic(bic1), .char_done(done1),
    .fifo_full(full1), .fifo_empty(empty1), .overflow(ovf1)
  );

  // Odd parity, two stop bits.
  serial_char_tx #(
    .DATA_W(8), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(4),
    .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)
  ) dut2 (
    .clk(clk), .reset(reset), .load(load2), .data_in(data2), .transmit(transmit2),
    .tx_serial(tx2), .busy(busy2), .bic(bic2), .char_done(done2),
    .fifo_full(full2), .fifo_empty(empty2), .overflow(ovf2)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Walks one whole frame starting on its first cycle; returns on the cycle after it.
  task automatic expect_frame(input logic [7:0] d, input bit sel, input string tag);
    logic bits[$];
    int   nb;
    bit   last;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    bits.push_back((^d) ^ sel);
    for (int s = 0; s < (sel ? 2 : 1); s++) bits.push_back(1'b1);
    nb = bits.size();
    for (int k = 0; k < nb; k++) begin
      for (int c = 0; c < CPB; c++) begin
        last = (c == CPB - 1);
        check({tag, "_tx"},   32'(sel ? tx2 : tx1),     32'(bits[k]));
        check({tag, "_busy"}, 32'(sel ? busy2 : busy1), 32'd1);
        check({tag, "_bic"},  32'(sel ? bic2 : bic1),   32'(last ? k + 1 : k));
        check({tag, "_done"}, 32'(sel ? done2 : done1), 32'(last && (k == nb - 1)));
        tick();
      end
    end
  endtask

  task automatic check_idle1(input string tag);
    check({tag, "_tx"},   32'(tx1),   32'd1);
    check({tag, "_busy"}, 32'(busy1), 32'd0);
    check({tag, "_bic"},  32'(bic1),  32'd0);
    check({tag, "_done"}, 32'(done1), 32'd0);
  endtask

  // Loads words on consecutive cycles with transmit high while checking the frames.
  task automatic burst(input logic [7:0] words[$], input string tag);
    int n = words.size();
    transmit1 = 1'b1;
    fork
      begin
        for (int i = 0; i < n; i++) begin
          load1 = 1'b1;
          data1 = words[i];
          tick();
        end
        load1 = 1'b0;
      end
      begin
        tick();
        tick();
        for (int k = 0; k < n; k++) begin
          check({tag, "_empty_at_start"}, 32'(empty1), 32'(k == n - 1));
          expect_frame(words[k], 1'b0, tag);
        end
      end
    join
    check_idle1({tag, "_after"});
    check({tag, "_empty_after"}, 32'(empty1), 32'd1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    logic [7:0] w[$];
    logic [7:0] lost;
    reset = 1'b0; load1 = 1'b0; transmit1 = 1'b0; data1 = '0;
    load2 = 1'b0; transmit2 = 1'b0; data2 = '0;
    tick();
    do_reset();

    // Reset state.
    check_idle1("reset");
    check("reset_empty", 32'(empty1), 32'd1);
    check("reset_full",  32'(full1),  32'd0);
    check("reset_ovf",   32'(ovf1),   32'd0);

    // Single 0xA5 frame; line must stay high until the cycle after the pop is sampled.
    transmit1 = 1'b1;
    load1 = 1'b1; data1 = 8'hA5;
    tick();
    load1 = 1'b0;
    check("a5_latency_tx",    32'(tx1),    32'd1);
    check("a5_latency_empty", 32'(empty1), 32'd0);
    tick();
    expect_frame(8'hA5, 1'b0, "a5");
    check_idle1("a5_after");
    check("a5_empty_after", 32'(empty1), 32'd1);

    // Three back-to-back frames with no idle gap.
    w = '{8'h01, 8'h02, 8'h03};
    burst(w, "b2b");

    // Random bursts.
    for (int r = 0; r < 3; r++) begin
      w.delete();
      for (int i = 0; i < int'($urandom_range(4, 1)); i++) w.push_back(8'($urandom));
      burst(w, "rnd");
    end

    // Overflow: five loads into a depth-4 FIFO while transmit is low.
    transmit1 = 1'b0;
    w.delete();
    for (int i = 0; i < 4; i++) w.push_back(8'($urandom));
    lost = 8'($urandom);
    for (int i = 0; i < 4; i++) begin
      load1 = 1'b1; data1 = w[i];
      tick();
    end
    check("ovf_full_after4", 32'(full1), 32'd1);
    check("ovf_flag_after4", 32'(ovf1),  32'd0);
    data1 = lost;
    tick();
    load1 = 1'b0;
    check("ovf_full_after5", 32'(full1), 32'd1);
    check("ovf_flag_after5", 32'(ovf1),  32'd1);
    check("ovf_idle_busy",   32'(busy1), 32'd0);
    transmit1 = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) expect_frame(w[k], 1'b0, "ovf");
    check_idle1("ovf_after");
    check("ovf_empty_after", 32'(empty1), 32'd1);
    check("ovf_sticky",      32'(ovf1),   32'd1);
    do_reset();
    check("ovf_cleared", 32'(ovf1), 32'd0);

    // Full FIFO with a load on the same cycle the first frame pops.
    transmit1 = 1'b0;
    w.delete();
    for (int i = 0; i < 5; i++) w.push_back(8'($urandom));
    for (int i = 0; i < 4; i++) begin
      load1 = 1'b1; data1 = w[i];
      tick();
    end
    check("popload_full_before", 32'(full1), 32'd1);
    transmit1 = 1'b1;
    load1 = 1'b1; data1 = w[4];
    tick();
    load1 = 1'b0;
    check("popload_ovf",  32'(ovf1),  32'd0);
    check("popload_full", 32'(full1), 32'd1);
    for (int k = 0; k < 5; k++) expect_frame(w[k], 1'b0, "popload");
    check_idle1("popload_after");
    check("popload_ovf_after", 32'(ovf1), 32'd0);

    // Odd parity, two stop bits, all-ones character: 48-cycle frame.
    transmit2 = 1'b1;
    load2 = 1'b1; data2 = 8'hFF;
    tick();
    load2 = 1'b0;
    check("odd_latency_tx", 32'(tx2), 32'd1);
    tick();
    expect_frame(8'hFF, 1'b1, "odd2");
    check("odd2_idle_busy", 32'(busy2), 32'd0);
    check("odd2_idle_tx",   32'(tx2),   32'd1);
    transmit2 = 1'b0;

    // Reset in the middle of the data bits, with a second word still queued.
    transmit1 = 1'b1;
    load1 = 1'b1; data1 = 8'h3C;
    tick();
    data1 = 8'hC3;
    tick();
    load1 = 1'b0;
    repeat (10) tick();
    check("mid_busy_before", 32'(busy1),  32'd1);
    check("mid_empty_before", 32'(empty1), 32'd0);
    reset = 1'b1;
    tick();
    check_idle1("mid_reset");
    check("mid_reset_empty", 32'(empty1), 32'd1);
    reset = 1'b0;
    for (int i = 0; i < 2 * CPB; i++) begin
      tick();
      check("mid_no_done", 32'(done1), 32'd0);
      check("mid_no_busy", 32'(busy1), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
